// File: rtl/data_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter.
package data_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DMA_RUN  = 2'd1,
    CPU_SLOT = 2'd2
  } arb_state_e;

  localparam logic [2:0] MEMCTRL_WORD    = 3'b000;
  localparam logic [2:0] MEMCTRL_BYTE_WR = 3'b010;
  localparam logic [2:0] MEMCTRL_BYTE_RD = 3'b011;

  // DMA words always move whole, word-aligned words.
  function automatic logic is_byte_ctrl(input logic [2:0] ctrl);
    return (ctrl == MEMCTRL_BYTE_WR) || (ctrl == MEMCTRL_BYTE_RD);
  endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Burst address/length tracker: latches the start of a burst, then steps
// one word per accepted DMA access and flags the final word.
module dma_addr_gen #(
  parameter int WAM = 17,
  parameter int LW  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [WAM:0]  start_addr_i,
  input  logic [LW-1:0] len_i,
  output logic [WAM:0]  addr_o,
  output logic          last_o
);

  logic [WAM:0]  addr_q, addr_d;
  logic [LW-1:0] rem_q, rem_d;

  // Next address/remaining count: load wins over step; address wraps naturally.
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load_i) begin
      addr_d = start_addr_i & ~((WAM+1)'(3));
      rem_d  = len_i;
    end else if (step_i) begin
      addr_d = addr_q + (WAM+1)'(4);
      rem_d  = rem_q - LW'(1);
    end
  end

  // Burst pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (rem_q == LW'(1));

endmodule

// File: rtl/data_mem_arbiter.sv
// Data-RAM port arbiter between the CPU MEM stage and a word-burst DMA requester.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | CPU owns the port; DMA burst may be accepted here
//   DMA_RUN  | one DMA word per cycle; CPU stalled if it is requesting
//   CPU_SLOT | single cycle handed back to a waiting CPU mid-burst
module data_mem_arbiter
  import data_arb_pkg::*;
#(
  parameter int WAM     = 17,
  parameter int WD      = 32,
  parameter int LW      = 8,
  parameter int SLICE   = 4,
  parameter int CPU_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          memreadM,
  input  logic          memwriteM,
  input  logic [WAM:0]  aluresultM,
  input  logic [WD-1:0] writedataM,
  input  logic [2:0]    memctrlM,
  output logic [WD-1:0] readdataM,
  output logic          stallM,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [WAM:0]  dma_addr,
  input  logic [LW-1:0] dma_len,
  input  logic [WD-1:0] dma_wdata,
  output logic          dma_busy,
  output logic          dma_ack,
  output logic [WD-1:0] dma_rdata,
  output logic          dma_done,
  output logic [WAM:0]  ram_addr,
  output logic          ram_re,
  output logic          ram_we,
  output logic [2:0]    ram_ctrl,
  output logic [WD-1:0] ram_wdata,
  input  logic [WD-1:0] ram_rdata
);

  localparam int STW = $clog2(CPU_MAX + 1);
  localparam int SLW = $clog2(SLICE + 1);
  localparam logic [STW-1:0] STARVE_MAX = STW'(CPU_MAX);
  localparam logic [SLW-1:0] SLICE_LAST = SLW'(SLICE - 1);

  arb_state_e     state_q, state_d;
  logic [STW-1:0] starve_q, starve_d;
  logic [SLW-1:0] slice_q, slice_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dma_we_q, dma_we_d;

  logic           cpu_req;
  logic           cpu_grant;
  logic           accept;
  logic           dma_step;
  logic           dma_last;
  logic [WAM:0]   dma_cur_addr;

  assign cpu_req = memreadM | memwriteM;

  dma_addr_gen #(
    .WAM (WAM),
    .LW  (LW)
  ) u_addr_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (accept),
    .step_i       (dma_step),
    .start_addr_i (dma_addr),
    .len_i        (dma_len),
    .addr_o       (dma_cur_addr),
    .last_o       (dma_last)
  );

  // FSM state and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      slice_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dma_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      slice_q  <= slice_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dma_we_q <= dma_we_d;
    end
  end

  // Next-state, fairness counters and grant decisions.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    slice_d   = slice_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dma_we_d  = dma_we_q;
    accept    = 1'b0;
    dma_step  = 1'b0;
    cpu_grant = 1'b0;
    unique case (state_q)
      IDLE: begin
        cpu_grant = cpu_req;
        if (dma_req && (!cpu_req || starve_q == STARVE_MAX)) begin
          accept   = 1'b1;
          starve_d = '0;
          slice_d  = '0;
          dma_we_d = dma_we;
          // A zero-length burst never touches RAM; it just reports completion.
          if (dma_len == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = DMA_RUN;
          end
        end else if (dma_req && cpu_req) begin
          starve_d = starve_q + STW'(1);
        end else begin
          starve_d = '0;
        end
      end
      DMA_RUN: begin
        dma_step = 1'b1;
        if (dma_last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          slice_d = '0;
        end else if (cpu_req) begin
          if (slice_q == SLICE_LAST) begin
            state_d = CPU_SLOT;
            slice_d = '0;
          end else begin
            slice_d = slice_q + SLW'(1);
          end
        end else begin
          slice_d = '0;
        end
      end
      CPU_SLOT: begin
        cpu_grant = cpu_req;
        state_d   = DMA_RUN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // RAM port mux: the DMA word when it runs, otherwise the CPU passes straight through.
  always_comb begin
    ram_addr  = aluresultM;
    ram_re    = memreadM;
    ram_we    = memwriteM;
    ram_ctrl  = memctrlM;
    ram_wdata = writedataM;
    if (dma_step) begin
      ram_addr  = dma_cur_addr;
      ram_re    = !dma_we_q;
      ram_we    = dma_we_q;
      ram_ctrl  = MEMCTRL_WORD;
      ram_wdata = dma_wdata;
    end
  end

  assign readdataM = (cpu_grant && memreadM) ? ram_rdata : '0;
  assign stallM    = cpu_req && !cpu_grant;
  assign dma_ack   = dma_step;
  assign dma_rdata = (dma_step && !dma_we_q) ? ram_rdata : '0;
  assign dma_busy  = busy_q;
  assign dma_done  = done_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a byte-addressed RAM model.
module tb_data_mem_arbiter;

  localparam int WAM = 17;
  localparam int WD  = 32;
  localparam int LW  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          memreadM, memwriteM;
  logic [WAM:0]  aluresultM;
  logic [WD-1:0] writedataM;
  logic [2:0]    memctrlM;
  logic [WD-1:0] readdataM;
  logic          stallM;
  logic          dma_req, dma_we;
  logic [WAM:0]  dma_addr;
  logic [LW-1:0] dma_len;
  logic [WD-1:0] dma_wdata;
  logic          dma_busy, dma_ack, dma_done;
  logic [WD-1:0] dma_rdata;
  logic [WAM:0]  ram_addr;
  logic          ram_re, ram_we;
  logic [2:0]    ram_ctrl;
  logic [WD-1:0] ram_wdata;
  logic [WD-1:0] ram_rdata;

  logic          bd_we = 1'b0;
  logic [WAM:0]  bd_addr = '0;
  logic [WD-1:0] bd_data = '0;

  logic [7:0] mem [0:(1<<(WAM+1))-1];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .memreadM   (memreadM),
    .memwriteM  (memwriteM),
    .aluresultM (aluresultM),
    .writedataM (writedataM),
    .memctrlM   (memctrlM),
    .readdataM  (readdataM),
    .stallM     (stallM),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_len    (dma_len),
    .dma_wdata  (dma_wdata),
    .dma_busy   (dma_busy),
    .dma_ack    (dma_ack),
    .dma_rdata  (dma_rdata),
    .dma_done   (dma_done),
    .ram_addr   (ram_addr),
    .ram_re     (ram_re),
    .ram_we     (ram_we),
    .ram_ctrl   (ram_ctrl),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // RAM model: combinational read, synchronous write, plus a bench backdoor port.
  always_comb begin
    ram_rdata = '0;
    if (ram_re) begin
      if (ram_ctrl == 3'b011)
        ram_rdata = {24'h0, mem[ram_addr]};
      else
        ram_rdata = {mem[ram_addr + 18'd3], mem[ram_addr + 18'd2],
                     mem[ram_addr + 18'd1], mem[ram_addr]};
    end
  end

  always @(posedge clk) begin
    if (bd_we) begin
      {mem[bd_addr + 18'd3], mem[bd_addr + 18'd2], mem[bd_addr + 18'd1], mem[bd_addr]} = bd_data;
    end else if (ram_we) begin
      if (ram_ctrl == 3'b010)
        mem[ram_addr] = ram_wdata[7:0];
      else
        {mem[ram_addr + 18'd3], mem[ram_addr + 18'd2], mem[ram_addr + 18'd1], mem[ram_addr]} = ram_wdata;
    end
  end

  function automatic logic [31:0] rd_word(input logic [WAM:0] a);
    return {mem[a + 18'd3], mem[a + 18'd2], mem[a + 18'd1], mem[a]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input logic [WAM:0] a, input logic [31:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    cyc();
    bd_we   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_busy, done_cyc, done_cnt, k, run, max_run, early_stall, bad_cnt;
    logic [11:0] ack_bits;

    memreadM = 0; memwriteM = 0; aluresultM = '0; writedataM = '0; memctrlM = 3'b000;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_len = '0; dma_wdata = '0;

    cyc();
    for (int i = 0; i < 10; i++) bd_write(18'h400 + 18'(4 * i), 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 5; i++)  bd_write(18'h600 + 18'(4 * i), 32'h0);
    for (int i = 0; i < 4; i++)  bd_write(18'h200 + 18'(4 * i), 32'h0);

    // Reset state
    @(negedge clk);
    chk("rst_busy",  32'(dma_busy), 32'd0);
    chk("rst_done",  32'(dma_done), 32'd0);
    chk("rst_ack",   32'(dma_ack),  32'd0);
    chk("rst_re",    32'(ram_re),   32'd0);
    chk("rst_we",    32'(ram_we),   32'd0);
    chk("rst_stall", 32'(stallM),   32'd0);
    chk("rst_rdata", readdataM,     32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // CPU only: word store, byte store, word load, byte load
    memwriteM = 1; aluresultM = 18'h10000; writedataM = 32'hDEAD_BEEF; memctrlM = 3'b000;
    @(negedge clk);
    chk("cpu_sw_we",    32'(ram_we),   32'd1);
    chk("cpu_sw_addr",  32'(ram_addr), 32'h10000);
    chk("cpu_sw_stall", 32'(stallM),   32'd0);
    cyc();
    aluresultM = 18'h10002; writedataM = 32'h0000_0055; memctrlM = 3'b010;
    @(negedge clk);
    chk("cpu_sb_ctrl", 32'(ram_ctrl), 32'd2);
    cyc();
    memwriteM = 0; memreadM = 1; aluresultM = 18'h10000; memctrlM = 3'b000;
    @(negedge clk);
    chk("cpu_lw_data",  readdataM,   32'hDE55_BEEF);
    chk("cpu_lw_stall", 32'(stallM), 32'd0);
    cyc();
    aluresultM = 18'h10001; memctrlM = 3'b011;
    @(negedge clk);
    chk("cpu_lb_data", readdataM, 32'h0000_00BE);
    cyc();
    memreadM = 0; memctrlM = 3'b000;
    @(negedge clk);
    chk("cpu_idle_rdata", readdataM, 32'd0);
    cyc();

    // DMA write len=4 at 0x202 (low bits ignored), CPU idle
    dma_req = 1; dma_we = 1; dma_addr = 18'h202; dma_len = 8'd4;
    @(negedge clk);
    chk("dw_acc_ack",  32'(dma_ack),  32'd0);
    chk("dw_acc_busy", 32'(dma_busy), 32'd0);
    cyc();
    dma_req = 0;
    for (int i = 0; i < 4; i++) begin
      dma_wdata = 32'h1111_0000 + 32'(i);
      @(negedge clk);
      chk("dw_ack",   32'(dma_ack),  32'd1);
      chk("dw_addr",  32'(ram_addr), 32'h200 + 32'(4 * i));
      chk("dw_we",    32'(ram_we),   32'd1);
      chk("dw_ctrl",  32'(ram_ctrl), 32'd0);
      chk("dw_busy",  32'(dma_busy), 32'd1);
      chk("dw_ndone", 32'(dma_done), 32'd0);
      cyc();
    end
    @(negedge clk);
    chk("dw_done",      32'(dma_done), 32'd1);
    chk("dw_done_busy", 32'(dma_busy), 32'd0);
    chk("dw_done_ack",  32'(dma_ack),  32'd0);
    cyc();
    @(negedge clk);
    chk("dw_done_pulse", 32'(dma_done), 32'd0);
    for (int i = 0; i < 4; i++) chk("dw_mem", rd_word(18'h200 + 18'(4 * i)), 32'h1111_0000 + 32'(i));
    cyc();

    // DMA read len=10 against a CPU load held the whole time
    memreadM = 1; aluresultM = 18'h10000; memctrlM = 3'b000;
    dma_req = 1; dma_we = 0; dma_addr = 18'h400; dma_len = 8'd10;
    first_busy = 0; done_cyc = 0; done_cnt = 0; k = 0; run = 0; max_run = 0;
    early_stall = 0; ack_bits = '0;
    for (int c = 1; c <= 24; c++) begin
      if (c == 23) dma_req = 0;
      @(negedge clk);
      if (dma_busy && first_busy == 0) first_busy = c;
      if (c >= 10 && c <= 21) ack_bits[21 - c] = dma_ack;
      if (dma_ack) begin
        chk("dr_rdata", dma_rdata, 32'hA000_0000 + 32'(k));
        k++;
      end
      if (dma_done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (stallM) begin
        run++;
        if (run > max_run) max_run = run;
        if (c < 10) early_stall++;
      end else begin
        run = 0;
      end
      if (c == 10) chk("dr_stalled_rdata", readdataM, 32'd0);
      if (c == 14) chk("dr_slot_rdata",    readdataM, 32'hDE55_BEEF);
      if (c == 24) chk("dr_idle_busy",     32'(dma_busy), 32'd0);
      cyc();
    end
    chk("dr_accept_cyc", 32'(first_busy),  32'd10);
    chk("dr_early_stall", 32'(early_stall), 32'd0);
    chk("dr_ack_pattern", 32'(ack_bits),   32'b1111_0111_1011);
    chk("dr_words",      32'(k),           32'd10);
    chk("dr_max_stall",  32'(max_run),     32'd4);
    chk("dr_done_cyc",   32'(done_cyc),    32'd22);
    chk("dr_done_cnt",   32'(done_cnt),    32'd1);
    memreadM = 0;

    // Zero-length burst
    dma_req = 1; dma_we = 1; dma_addr = 18'h300; dma_len = 8'd0;
    @(negedge clk);
    chk("z_acc_we", 32'(ram_we), 32'd0);
    chk("z_acc_re", 32'(ram_re), 32'd0);
    cyc();
    dma_req = 0;
    @(negedge clk);
    chk("z_done", 32'(dma_done), 32'd1);
    chk("z_busy", 32'(dma_busy), 32'd0);
    chk("z_ack",  32'(dma_ack),  32'd0);
    chk("z_we",   32'(ram_we),   32'd0);
    cyc();
    @(negedge clk);
    chk("z_done_pulse", 32'(dma_done), 32'd0);
    cyc();

    // Reset after 2 of 5 write words
    dma_req = 1; dma_we = 1; dma_addr = 18'h600; dma_len = 8'd5;
    @(negedge clk);
    cyc();
    dma_req = 0;
    for (int i = 0; i < 2; i++) begin
      dma_wdata = 32'h2222_0000 + 32'(i);
      @(negedge clk);
      chk("rs_ack", 32'(dma_ack), 32'd1);
      cyc();
    end
    dma_wdata = 32'h2222_0002;
    rst_n = 1'b0;
    #1;
    chk("rs_busy", 32'(dma_busy), 32'd0);
    chk("rs_ack0", 32'(dma_ack),  32'd0);
    chk("rs_we",   32'(ram_we),   32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    bad_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (dma_done || dma_ack || dma_busy) bad_cnt++;
      cyc();
    end
    chk("rs_quiet", 32'(bad_cnt), 32'd0);
    chk("rs_w0", rd_word(18'h600), 32'h2222_0000);
    chk("rs_w1", rd_word(18'h604), 32'h2222_0001);
    chk("rs_w2", rd_word(18'h608), 32'h0);
    chk("rs_w3", rd_word(18'h60C), 32'h0);
    chk("rs_w4", rd_word(18'h610), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
